// File: rtl/dual_clock_fifo_pkg.sv
// Shared defaults and pointer-width helpers for dual_clock_fifo.
package dual_clock_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // One extra wrap bit distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dual_clock_fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage, synchronous write port and asynchronous read-address port.
module fifo_mem
  import dual_clock_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/dual_clock_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a registered read port.
// Optional sticky overflow/underflow outputs enabled by DUAL_CLOCK_FIFO_ERR_FLAGS_EN.
module dual_clock_fifo
  import dual_clock_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              full,
  output logic              empty
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_ok;
  logic              rd_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign wr_ok = write_en && !full;
  assign rd_ok = read_en && !empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk        (wclk),
    .write_en   (wr_ok),
    .write_addr (wptr[ADDR_W-1:0]),
    .write_data (write_data),
    .read_addr  (rptr[ADDR_W-1:0]),
    .read_data  (mem_rdata)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      read_data <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr      <= rptr + 1'b1;
        read_data <= mem_rdata;
      end
    end
  end

`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full) overflow  <= 1'b1;
      if (read_en && empty) underflow <= 1'b1;
    end
  end
`else
  // Error tracking is compiled out; no extra ports or state.
`endif

endmodule

// File: tb/tb_dual_clock_fifo.sv
// Directed self-checking bench for dual_clock_fifo (DEPTH=4, DATA_W=8).
module tb_dual_clock_fifo;

  logic       wclk;
  logic       wrst_n;
  logic       write_en;
  logic [7:0] write_data;
  logic       read_en;
  logic [7:0] read_data;
  logic       full;
  logic       empty;
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  dual_clock_fifo #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty)
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    write_en   = 1'b1;
    write_data = d;
    read_en    = 1'b0;
    step();
    idle();
  endtask

  task automatic rd();
    write_en = 1'b0;
    read_en  = 1'b1;
    step();
    idle();
  endtask

  logic [7:0] exp_rd [4] = '{8'h33, 8'h44, 8'h66, 8'h77};

  initial begin
    wrst_n     = 1'b0;
    write_en   = 1'b0;
    write_data = 8'h00;
    read_en    = 1'b0;
    #12;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_rdata", {24'b0, read_data}, 32'h00);
    step();
    wrst_n = 1'b1;
    step();
    step();
    chk("post_rst_empty", {31'b0, empty}, 32'd1);
    chk("post_rst_full", {31'b0, full}, 32'd0);
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_unf", {31'b0, underflow}, 32'd0);
`endif

    wr(8'h11);
    chk("wr1_empty", {31'b0, empty}, 32'd0);
    chk("wr1_full", {31'b0, full}, 32'd0);
    wr(8'h22);
    wr(8'h33);
    chk("wr3_full", {31'b0, full}, 32'd0);
    wr(8'h44);
    chk("wr4_full", {31'b0, full}, 32'd1);

    wr(8'h55);
    chk("ovf_full", {31'b0, full}, 32'd1);
    chk("ovf_rdata_hold", {24'b0, read_data}, 32'h00);
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
`endif

    rd();
    chk("rd1", {24'b0, read_data}, 32'h11);
    chk("rd1_full", {31'b0, full}, 32'd0);
    rd();
    chk("rd2", {24'b0, read_data}, 32'h22);

    wr(8'h66);
    chk("wr66_full", {31'b0, full}, 32'd0);
    wr(8'h77);
    chk("wrap_full", {31'b0, full}, 32'd1);

    // Simultaneous read and write at full: only the read goes through.
    write_en = 1'b1; write_data = 8'hEE; read_en = 1'b1;
    step();
    idle();
    chk("rw_full_rdata", {24'b0, read_data}, 32'h33);
    chk("rw_full_full", {31'b0, full}, 32'd0);
    wr(8'hEE);
    chk("refill_full", {31'b0, full}, 32'd1);
    exp_rd = '{8'h44, 8'h66, 8'h77, 8'hEE};

    for (int i = 0; i < 4; i++) begin
      rd();
      chk($sformatf("drain%0d", i), {24'b0, read_data}, {24'b0, exp_rd[i]});
    end
    chk("drain_empty", {31'b0, empty}, 32'd1);
    rd();
    chk("unf_rdata_hold", {24'b0, read_data}, 32'hEE);
    chk("unf_empty", {31'b0, empty}, 32'd1);
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
    chk("unf_flag", {31'b0, underflow}, 32'd1);
`endif

    // Simultaneous read and write at empty: only the write goes through.
    write_en = 1'b1; write_data = 8'h88; read_en = 1'b1;
    step();
    idle();
    chk("rw_empty_rdata", {24'b0, read_data}, 32'hEE);
    chk("rw_empty_empty", {31'b0, empty}, 32'd0);

    // Both accepted with one entry stored: occupancy stays at one.
    write_en = 1'b1; write_data = 8'h99; read_en = 1'b1;
    step();
    idle();
    chk("rw_mid_rdata", {24'b0, read_data}, 32'h88);
    chk("rw_mid_empty", {31'b0, empty}, 32'd0);

    wr(8'hAA);
    chk("two_stored_empty", {31'b0, empty}, 32'd0);
    #2;
    wrst_n = 1'b0;
    #1;
    chk("async_rst_empty", {31'b0, empty}, 32'd1);
    chk("async_rst_rdata", {24'b0, read_data}, 32'h00);
`ifdef DUAL_CLOCK_FIFO_ERR_FLAGS_EN
    chk("async_rst_ovf", {31'b0, overflow}, 32'd0);
    chk("async_rst_unf", {31'b0, underflow}, 32'd0);
`endif
    step();
    wrst_n = 1'b1;
    step();
    wr(8'hA5);
    rd();
    chk("post_rst_rd", {24'b0, read_data}, 32'hA5);
    chk("post_rst_rd_empty", {31'b0, empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
